divmmc_mapper: RTL and testbench
================================

Name: divmmc_mapper

Overview:
- Next-generation DivMMC interface for the ZX Spectrum core; replaces the fixed 4-bit/single-card design.
- Adds a parametrised SRAM page width, N SD chip-selects, a sticky MAPRAM mode with write protection, an NMI button path, and a native SPI master with a programmable clock divider and a busy flag.
- Sits between the Z80 bus decode and the SDRAM mapper and drives the physical SPI pins directly.

Parameters:
- PAGE_BITS, 6, SRAM page select width (6 gives 512 KB as 64 x 8 KB banks).
- NUM_CS, 2, number of SD chip-select lines.
- SPI_DIV, 2, SCK half-period in clk cycles (1 or more).
- TRAP_ROM3, 1, enables the 0x04C6 and 0x0562 tape traps.

Ports:
- clk in 1: system clock.
- nRESET in 1: asynchronous, active-low reset.
- enabled in 1: synchronous soft disable.
- addr in 16; din in 8; nWR, nRD, nMREQ, nIORQ, nM1 in 1 each: Z80 bus.
- dout out 8: SPI receive register.
- active out 1: the divmmc memory overlay owns 0000-3FFF.
- active_io out 1: I/O read of port EB is being claimed.
- mapped_addr out PAGE_BITS+14: bit MSB=1 selects RAM, MSB=0 selects ROM.
- mem_wr_en out 1: the current overlay write is permitted.
- nmi_button in 1: level, already synchronised.
- nNMI out 1: NMI to the CPU.
- spi_busy out 1: SPI transfer in progress.
- sd_cs_n out NUM_CS; sd_sck out 1; sd_mosi out 1; sd_miso in 1: SPI pins.
- sd_activity out 1: OR of the inverted sd_cs_n bits.

Behaviour:
- Bus decode:
  - io_we = !nIORQ & !nWR & nM1.
  - io_rd = !nIORQ & !nRD & nM1.
  - op_rd = !nMREQ & !nRD & !nM1.
  - Each access acts once, on its first clk with the condition true (edge-detected).
  - Port writes and reads are decoded whenever enabled=1, independent of active.
- Port E3 write:
  - page <= din[PAGE_BITS-1:0], but bits above bit 5 are taken as 0.
  - conmem <= din[7].
  - din[6]=1 sets mapram.
  - mapram is sticky: it is cleared only by nRESET, not by enabled=0.
- Port E7 write: sd_cs_n <= din[NUM_CS-1:0].
- Port EB write: starts a transfer of din.
- Port EB read:
  - Returns dout and raises active_io for the duration of the read.
  - Starts a transfer of 0xFF; the result appears in dout for the next read.
  - A strobe arriving while spi_busy=1 is dropped.
- SPI (mode 0):
  - MSB first; MOSI changes on the falling edge, MISO is sampled on the rising edge.
  - sd_sck idles low.
  - A transfer takes exactly 16*SPI_DIV clks.
  - spi_busy rises the clk after the strobe and falls with dout valid.
- Automap (active = memactive | conmem):
  - op_rd at 0000, 0008, 0038, 0066, plus 04C6 and 0562 when TRAP_ROM3=1: sets m1_trigger.
  - op_rd at 3Dxx: sets both memactive and m1_trigger immediately.
  - op_rd at 1FF8-1FFF: clears m1_trigger.
  - While nM1=1: memactive <= m1_trigger.
- NMI:
  - A rising edge of nmi_button while active=0 latches nmi_req, and nNMI=0.
  - op_rd at 0066 clears nmi_req, so nNMI=1.
  - Presses while active=1 or nmi_req=1 are ignored.
- Memory map when active=1 (A=addr):
  - conmem=1: 0000-1FFF maps to ROM A[12:0], mem_wr_en=1. 2000-3FFF maps to RAM {page,A[12:0]}, mem_wr_en=1.
  - conmem=0, mapram=1: 0000-1FFF maps to RAM bank 3, mem_wr_en=0. 2000-3FFF maps to RAM page, mem_wr_en = (page!=3).
  - Otherwise: 0000-1FFF maps to ROM, mem_wr_en=0. 2000-3FFF maps to RAM page, mem_wr_en=1.
  - mapped_addr and mem_wr_en are combinational. mem_wr_en=0 whenever active=0.
- Reset values (nRESET=0):
  - page, conmem, mapram, memactive, m1_trigger, nmi_req = 0.
  - sd_cs_n all 1; nNMI=1; dout=0xFF; sd_sck=0; sd_mosi=1; spi_busy=0.
- enabled=0 (synchronous):
  - Clears everything cleared by reset except mapram.
  - Aborts any SPI transfer, leaving dout unchanged.
- Reset mid-transfer: the transfer aborts immediately and the pins return to idle.

Decomposition:
- Shared package divmmc_pkg holds:
  - Port constants PORT_CTRL=E3, PORT_CS=E7, PORT_SPI=EB.
  - The trap address constants.
  - The MAPRAM_BANK=3 constant.
- Sub-module divmmc_spi (parameter SPI_DIV): byte shift engine containing a counter, shift register and busy flag.

Test Plan:
- Reset, then write E3=0x83 -> active=1; mapped_addr for 0x2010 = {1, page 3, 0x0010}; mem_wr_en=1.
- Opcode fetch at 0x0038, then nM1 high -> active=1. Fetch at 0x1FF8, then nM1 high -> active=0. A fetch at 0x3D00 -> active=1 on the next clk, with no wait for M1 to end.
- Write E3=0x40, then pulse enabled=0, then trigger automap -> mapram persists; the 0x0100 write has mem_wr_en=0. Page 3 at 0x2000 gives mem_wr_en=0; page 4 gives 1.
- SPI_DIV=2, E7=0xFE, write EB=0xA5 with the MISO model returning 0x3C -> MOSI shows A5 MSB first; spi_busy lasts 32 clks; the next EB read returns 0x3C with active_io=1. A second write while busy is ignored.
- nmi_button pulse with active=0 -> nNMI=0 until the 0x0066 fetch. At the following nM1 high, nNMI=1 and active=1. A second press while active is ignored.
- Assert nRESET mid-SPI transfer -> sd_sck=0, sd_cs_n=all 1s, spi_busy=0, dout=0xFF, asynchronously.

Source files
------------

// File: rtl/divmmc_pkg.sv
`default_nettype none
// ============================================================================
// divmmc_pkg : shared constants, SPI state encoding and trap decode helper
// Rev 1.0
// ============================================================================
package divmmc_pkg;

    localparam logic [7:0]  PORT_CTRL    = 8'hE3;
    localparam logic [7:0]  PORT_CS      = 8'hE7;
    localparam logic [7:0]  PORT_SPI     = 8'hEB;

    localparam logic [15:0] TRAP_RST00   = 16'h0000;
    localparam logic [15:0] TRAP_RST08   = 16'h0008;
    localparam logic [15:0] TRAP_RST38   = 16'h0038;
    localparam logic [15:0] TRAP_NMI     = 16'h0066;
    localparam logic [15:0] TRAP_TAPE_LD = 16'h04C6;
    localparam logic [15:0] TRAP_TAPE_SV = 16'h0562;
    localparam logic [7:0]  TRAP_INSTANT_HI = 8'h3D;
    localparam logic [12:0] TRAP_OFF_HI  = 13'h03FF;

    localparam int          MAPRAM_BANK  = 3;

    typedef enum logic [0:0] {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_e;

    // Entry points that arm automap at the end of the current M1 cycle.
    function automatic logic is_entry_trap(input logic [15:0] a, input logic rom3_en);
        return (a == TRAP_RST00) || (a == TRAP_RST08) || (a == TRAP_RST38) ||
               (a == TRAP_NMI) ||
               (rom3_en && ((a == TRAP_TAPE_LD) || (a == TRAP_TAPE_SV)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/divmmc_mapper_if.sv
`default_nettype none
// ============================================================================
// divmmc_mapper_if : Z80 bus plus overlay mapping results
// Rev 1.0
// ============================================================================
interface divmmc_mapper_if #(
    parameter int PAGE_BITS = 6
);
    logic [15:0]            addr;
    logic [7:0]             din;
    logic                   nWR;
    logic                   nRD;
    logic                   nMREQ;
    logic                   nIORQ;
    logic                   nM1;
    logic [7:0]             dout;
    logic                   active;
    logic                   active_io;
    logic [PAGE_BITS+13:0]  mapped_addr;
    logic                   mem_wr_en;

    modport master (
        output addr, din, nWR, nRD, nMREQ, nIORQ, nM1,
        input  dout, active, active_io, mapped_addr, mem_wr_en
    );

    modport slave (
        input  addr, din, nWR, nRD, nMREQ, nIORQ, nM1,
        output dout, active, active_io, mapped_addr, mem_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/divmmc_spi.sv
`default_nettype none
// ============================================================================
// divmmc_spi : mode-0 SPI byte engine, MSB first, SCK half-period SPI_DIV clks
// Rev 1.0
// ============================================================================
module divmmc_spi
    import divmmc_pkg::*;
#(
    parameter int SPI_DIV = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       abort_i,
    input  wire logic       start_i,
    input  wire logic [7:0] tx_i,
    input  wire logic       miso_i,
    output logic            sck_o,
    output logic            mosi_o,
    output logic            busy_o,
    output logic [7:0]      rx_o
);
    localparam int CW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPI_DIV - 1);

    spi_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     half_q;
    logic [7:0]     sh_q;
    logic [7:0]     rx_q;
    logic           sck_q;
    logic           mosi_q;

    // 16 half-periods: even halves end with a rising edge (sample MISO),
    // odd halves end with a falling edge (present next MOSI bit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPI_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            sh_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
        end else if (abort_i) begin
            state_q <= SPI_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            case (state_q)
                SPI_IDLE: begin
                    if (start_i) begin
                        state_q <= SPI_SHIFT;
                        sh_q    <= tx_i;
                        mosi_q  <= tx_i[7];
                        cnt_q   <= '0;
                        half_q  <= '0;
                    end
                end
                SPI_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        half_q <= half_q + 4'd1;
                        if (half_q == 4'd15) begin
                            state_q <= SPI_IDLE;
                            sck_q   <= 1'b0;
                            mosi_q  <= 1'b1;
                            rx_q    <= sh_q;
                        end else if (!half_q[0]) begin
                            sck_q <= 1'b1;
                            sh_q  <= {sh_q[6:0], miso_i};
                        end else begin
                            sck_q  <= 1'b0;
                            mosi_q <= sh_q[7];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= SPI_IDLE;
            endcase
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign busy_o = (state_q == SPI_SHIFT);
    assign rx_o   = rx_q;

endmodule
`default_nettype wire

// File: rtl/divmmc_mapper.sv
`default_nettype none
// ============================================================================
// divmmc_mapper : DivMMC overlay mapper with automap, MAPRAM, NMI and SPI master
// Rev 1.0
// ============================================================================
module divmmc_mapper
    import divmmc_pkg::*;
#(
    parameter int PAGE_BITS = 6,
    parameter int NUM_CS    = 2,
    parameter int SPI_DIV   = 2,
    parameter int TRAP_ROM3 = 1
) (
    input  wire logic               clk,
    input  wire logic               nRESET,
    input  wire logic               enabled,
    divmmc_mapper_if.slave          bus,
    input  wire logic               nmi_button,
    output logic                    nNMI,
    output logic                    spi_busy,
    output logic [NUM_CS-1:0]       sd_cs_n,
    output logic                    sd_sck,
    output logic                    sd_mosi,
    input  wire logic               sd_miso,
    output logic                    sd_activity
);
    localparam int PG_LOAD = (PAGE_BITS < 6) ? PAGE_BITS : 6;
    localparam logic [PAGE_BITS-1:0] BANK3 = PAGE_BITS'(MAPRAM_BANK);

    logic [PAGE_BITS-1:0]   page_q;
    logic                   conmem_q, mapram_q, memactive_q, m1_trig_q, nmi_req_q;
    logic [NUM_CS-1:0]      cs_q;
    logic                   io_we_q, io_rd_q, op_rd_q, nmi_btn_q;

    logic                   w_io_we, w_io_rd, w_op_rd;
    logic                   w_io_we_p, w_io_rd_p, w_op_rd_p;
    logic [7:0]             w_port;
    logic                   w_active, w_spi_start;
    logic [7:0]             w_spi_tx;
    logic [PAGE_BITS-1:0]   w_page_din;
    logic                   w_map_ram, w_map_wr;
    logic [PAGE_BITS-1:0]   w_map_bank;

    assign w_io_we = !bus.nIORQ && !bus.nWR && bus.nM1;
    assign w_io_rd = !bus.nIORQ && !bus.nRD && bus.nM1;
    assign w_op_rd = !bus.nMREQ && !bus.nRD && !bus.nM1;
    assign w_io_we_p = w_io_we && !io_we_q && enabled;
    assign w_io_rd_p = w_io_rd && !io_rd_q && enabled;
    assign w_op_rd_p = w_op_rd && !op_rd_q && enabled;
    assign w_port    = bus.addr[7:0];
    assign w_active  = memactive_q || conmem_q;

    // din[7:6] carry conmem/mapram, so page bits above bit 5 are always zero.
    always_comb begin
        w_page_din = '0;
        for (int i = 0; i < PG_LOAD; i++) w_page_din[i] = bus.din[i];
    end

    assign w_spi_start = (w_io_we_p || w_io_rd_p) && (w_port == PORT_SPI);
    assign w_spi_tx    = w_io_we_p ? bus.din : 8'hFF;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            page_q      <= '0;
            conmem_q    <= 1'b0;
            mapram_q    <= 1'b0;
            memactive_q <= 1'b0;
            m1_trig_q   <= 1'b0;
            nmi_req_q   <= 1'b0;
            cs_q        <= '1;
            io_we_q     <= 1'b0;
            io_rd_q     <= 1'b0;
            op_rd_q     <= 1'b0;
            nmi_btn_q   <= 1'b0;
        end else begin
            io_we_q   <= w_io_we;
            io_rd_q   <= w_io_rd;
            op_rd_q   <= w_op_rd;
            nmi_btn_q <= nmi_button;
            if (!enabled) begin
                page_q      <= '0;
                conmem_q    <= 1'b0;
                memactive_q <= 1'b0;
                m1_trig_q   <= 1'b0;
                nmi_req_q   <= 1'b0;
                cs_q        <= '1;
            end else begin
                if (w_io_we_p && (w_port == PORT_CTRL)) begin
                    page_q   <= w_page_din;
                    conmem_q <= bus.din[7];
                    if (bus.din[6]) mapram_q <= 1'b1;
                end
                if (w_io_we_p && (w_port == PORT_CS)) cs_q <= bus.din[NUM_CS-1:0];

                if (w_op_rd_p && (bus.addr[15:8] == TRAP_INSTANT_HI)) begin
                    memactive_q <= 1'b1;
                    m1_trig_q   <= 1'b1;
                end else if (w_op_rd_p && is_entry_trap(bus.addr, TRAP_ROM3 != 0)) begin
                    m1_trig_q <= 1'b1;
                end else if (w_op_rd_p && (bus.addr[15:3] == TRAP_OFF_HI)) begin
                    m1_trig_q <= 1'b0;
                end
                if (bus.nM1) memactive_q <= m1_trig_q;

                if (w_op_rd_p && (bus.addr == TRAP_NMI)) begin
                    nmi_req_q <= 1'b0;
                end else if (nmi_button && !nmi_btn_q && !w_active && !nmi_req_q) begin
                    nmi_req_q <= 1'b1;
                end
            end
        end
    end

    // Lower 8 KB is ROM unless MAPRAM substitutes write-protected bank 3.
    always_comb begin
        w_map_ram  = 1'b1;
        w_map_bank = page_q;
        w_map_wr   = 1'b1;
        if (!bus.addr[13]) begin
            if (conmem_q) begin
                w_map_ram  = 1'b0;
                w_map_bank = '0;
            end else if (mapram_q) begin
                w_map_bank = BANK3;
                w_map_wr   = 1'b0;
            end else begin
                w_map_ram  = 1'b0;
                w_map_bank = '0;
                w_map_wr   = 1'b0;
            end
        end else begin
            w_map_wr = conmem_q || !mapram_q || (page_q != BANK3);
        end
    end

    assign bus.mapped_addr = {w_map_ram, w_map_bank, bus.addr[12:0]};
    assign bus.mem_wr_en   = w_active && (bus.addr[15:14] == 2'b00) && w_map_wr;
    assign bus.active      = w_active;
    assign bus.active_io   = w_io_rd && enabled && (w_port == PORT_SPI);

    divmmc_spi #(
        .SPI_DIV (SPI_DIV)
    ) u_spi (
        .clk     (clk),
        .rst_n   (nRESET),
        .abort_i (!enabled),
        .start_i (w_spi_start),
        .tx_i    (w_spi_tx),
        .miso_i  (sd_miso),
        .sck_o   (sd_sck),
        .mosi_o  (sd_mosi),
        .busy_o  (spi_busy),
        .rx_o    (bus.dout)
    );

    assign nNMI        = !nmi_req_q;
    assign sd_cs_n     = cs_q;
    assign sd_activity = |(~cs_q);

endmodule
`default_nettype wire

// File: tb/tb_divmmc_mapper.sv
`default_nettype none
// ============================================================================
// tb_divmmc_mapper : directed self-checking bench for divmmc_mapper
// Rev 1.0
// ============================================================================
module tb_divmmc_mapper;

    localparam logic [7:0] P_CTRL = 8'hE3;
    localparam logic [7:0] P_CS   = 8'hE7;
    localparam logic [7:0] P_SPI  = 8'hEB;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       enabled;
    logic       nmi_button;
    logic       nNMI;
    logic       spi_busy;
    logic [1:0] sd_cs_n;
    logic       sd_sck;
    logic       sd_mosi;
    logic       sd_miso;
    logic       sd_activity;

    int n_checks = 0;
    int n_fail   = 0;

    divmmc_mapper_if #(.PAGE_BITS(6)) bus ();

    divmmc_mapper #(
        .PAGE_BITS (6),
        .NUM_CS    (2),
        .SPI_DIV   (2),
        .TRAP_ROM3 (1)
    ) dut (
        .clk         (clk),
        .nRESET      (nRESET),
        .enabled     (enabled),
        .bus         (bus),
        .nmi_button  (nmi_button),
        .nNMI        (nNMI),
        .spi_busy    (spi_busy),
        .sd_cs_n     (sd_cs_n),
        .sd_sck      (sd_sck),
        .sd_mosi     (sd_mosi),
        .sd_miso     (sd_miso),
        .sd_activity (sd_activity)
    );

    always #5 clk = ~clk;

    // SD card model: shifts a byte out on falling SCK, captures MOSI on rising SCK.
    logic [7:0] miso_byte = 8'hFF;
    logic [7:0] mosi_cap  = 8'h00;
    int fall_cnt  = 0;
    int fall_base = 0;
    int rise_cnt  = 0;
    int miso_idx;

    always @(negedge sd_sck) fall_cnt++;
    always @(posedge sd_sck) begin
        mosi_cap = {mosi_cap[6:0], sd_mosi};
        rise_cnt++;
    end
    assign miso_idx = fall_cnt - fall_base;
    assign sd_miso  = (miso_idx >= 0 && miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b1;

    task automatic bus_idle();
        bus.nIORQ = 1'b1; bus.nWR = 1'b1; bus.nRD = 1'b1; bus.nMREQ = 1'b1; bus.nM1 = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        bus.addr = {8'h00, port}; bus.din = data; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic fetch(input logic [15:0] a);
        @(negedge clk);
        bus.addr = a; bus.nMREQ = 1'b0; bus.nRD = 1'b0; bus.nM1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic m1_end();
        bus_idle();
        @(negedge clk);
    endtask

    task automatic wait_spi_idle(output int cycles);
        cycles = 0;
        while (spi_busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", bus.active); end
        n_checks++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_wr_en); end
        n_checks++; if (nNMI !== 1'b1) begin n_fail++; $display("FAIL reset_nNMI: got %b want 1", nNMI); end
        n_checks++; if (sd_cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs: got %b want 11", sd_cs_n); end
        n_checks++; if (bus.dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout: got %h want ff", bus.dout); end
        n_checks++; if (sd_sck !== 1'b0 || sd_mosi !== 1'b1 || spi_busy !== 1'b0) begin n_fail++; $display("FAIL reset_spi_pins: got sck=%b mosi=%b busy=%b want 0 1 0", sd_sck, sd_mosi, spi_busy); end
        n_checks++; if (sd_activity !== 1'b0) begin n_fail++; $display("FAIL reset_activity: got %b want 0", sd_activity); end
        nRESET = 1'b1;
    endtask

    task automatic test_conmem();
        io_write(P_CTRL, 8'h83);
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL conmem_active: got %b want 1", bus.active); end
        bus.addr = 16'h2010; #1;
        n_checks++; if (bus.mapped_addr !== 20'h86010) begin n_fail++; $display("FAIL conmem_ram_addr: got %h want 86010", bus.mapped_addr); end
        n_checks++; if (bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL conmem_ram_wr: got %b want 1", bus.mem_wr_en); end
        bus.addr = 16'h0123; #1;
        n_checks++; if (bus.mapped_addr !== 20'h00123 || bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL conmem_rom: got %h/%b want 00123/1", bus.mapped_addr, bus.mem_wr_en); end
        io_write(P_CTRL, 8'h00);
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL conmem_off: got %b want 0", bus.active); end
    endtask

    task automatic test_automap();
        fetch(16'h0038);
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL automap_wait_m1: got %b want 0", bus.active); end
        m1_end();
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL automap_0038: got %b want 1", bus.active); end
        fetch(16'h1FF8); m1_end();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL automap_1ff8_off: got %b want 0", bus.active); end
        fetch(16'h0039); m1_end();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL automap_nontrap: got %b want 0", bus.active); end
        fetch(16'h04C6); m1_end();
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL automap_04c6: got %b want 1", bus.active); end
        fetch(16'h1FFF); m1_end();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL automap_1fff_off: got %b want 0", bus.active); end
        fetch(16'h3D00);
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL automap_3d_instant: got %b want 1", bus.active); end
        m1_end();
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL automap_3d_hold: got %b want 1", bus.active); end
        fetch(16'h1FF8); m1_end();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL automap_3d_off: got %b want 0", bus.active); end
    endtask

    task automatic test_mapram();
        io_write(P_CTRL, 8'h40);
        @(negedge clk); enabled = 1'b0;
        @(negedge clk); enabled = 1'b1;
        fetch(16'h0000); m1_end();
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL mapram_active: got %b want 1", bus.active); end
        bus.addr = 16'h0100; #1;
        n_checks++; if (bus.mapped_addr !== 20'h86100 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mapram_bank3_ro: got %h/%b want 86100/0", bus.mapped_addr, bus.mem_wr_en); end
        io_write(P_CTRL, 8'h03);
        bus.addr = 16'h2000; #1;
        n_checks++; if (bus.mapped_addr !== 20'h86000 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mapram_page3: got %h/%b want 86000/0", bus.mapped_addr, bus.mem_wr_en); end
        io_write(P_CTRL, 8'h04);
        bus.addr = 16'h2000; #1;
        n_checks++; if (bus.mapped_addr !== 20'h88000 || bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL mapram_page4: got %h/%b want 88000/1", bus.mapped_addr, bus.mem_wr_en); end
        fetch(16'h1FF8); m1_end();
        bus.addr = 16'h2000; #1;
        n_checks++; if (bus.active !== 1'b0 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mapram_inactive: got %b/%b want 0/0", bus.active, bus.mem_wr_en); end
        io_write(P_CTRL, 8'h83);
        bus.addr = 16'h0100; #1;
        n_checks++; if (bus.mapped_addr !== 20'h00100 || bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL mapram_conmem_rom: got %h/%b want 00100/1", bus.mapped_addr, bus.mem_wr_en); end
        bus.addr = 16'h2000; #1;
        n_checks++; if (bus.mapped_addr !== 20'h86000 || bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL mapram_conmem_page3: got %h/%b want 86000/1", bus.mapped_addr, bus.mem_wr_en); end
        io_write(P_CTRL, 8'h00);
    endtask

    task automatic test_spi();
        int cyc;
        int rbase;
        io_write(P_CS, 8'hFE);
        n_checks++; if (sd_cs_n !== 2'b10 || sd_activity !== 1'b1) begin n_fail++; $display("FAIL spi_cs: got %b/%b want 10/1", sd_cs_n, sd_activity); end
        miso_byte = 8'h3C; fall_base = fall_cnt; rbase = rise_cnt;
        @(negedge clk);
        bus.addr = {8'h00, P_SPI}; bus.din = 8'hA5; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        @(negedge clk);
        bus_idle();
        cyc = 0;
        while (spi_busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 8) begin bus.addr = {8'h00, P_SPI}; bus.din = 8'h00; bus.nIORQ = 1'b0; bus.nWR = 1'b0; end
            if (cyc == 10) bus_idle();
            @(negedge clk);
        end
        n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL spi_busy_len: got %0d want 32", cyc); end
        n_checks++; if (mosi_cap !== 8'hA5 || (rise_cnt - rbase) !== 8) begin n_fail++; $display("FAIL spi_mosi: got %h/%0d edges want a5/8", mosi_cap, rise_cnt - rbase); end
        n_checks++; if (bus.dout !== 8'h3C) begin n_fail++; $display("FAIL spi_rx: got %h want 3c", bus.dout); end
        n_checks++; if (sd_sck !== 1'b0 || sd_mosi !== 1'b1) begin n_fail++; $display("FAIL spi_idle_pins: got %b/%b want 0/1", sd_sck, sd_mosi); end

        miso_byte = 8'h81; fall_base = fall_cnt;
        @(negedge clk);
        bus.addr = {8'h00, P_SPI}; bus.nIORQ = 1'b0; bus.nRD = 1'b0; #1;
        n_checks++; if (bus.active_io !== 1'b1 || bus.dout !== 8'h3C) begin n_fail++; $display("FAIL spi_read1: got io=%b dout=%h want 1/3c", bus.active_io, bus.dout); end
        @(negedge clk);
        bus_idle(); #1;
        n_checks++; if (bus.active_io !== 1'b0 || spi_busy !== 1'b1) begin n_fail++; $display("FAIL spi_read1_start: got io=%b busy=%b want 0/1", bus.active_io, spi_busy); end
        wait_spi_idle(cyc);
        n_checks++; if (mosi_cap !== 8'hFF || bus.dout !== 8'h81) begin n_fail++; $display("FAIL spi_read1_xfer: got mosi=%h dout=%h want ff/81", mosi_cap, bus.dout); end

        miso_byte = 8'h42; fall_base = fall_cnt;
        @(negedge clk);
        bus.addr = {8'h00, P_SPI}; bus.nIORQ = 1'b0; bus.nRD = 1'b0; #1;
        n_checks++; if (bus.active_io !== 1'b1 || bus.dout !== 8'h81) begin n_fail++; $display("FAIL spi_read2: got io=%b dout=%h want 1/81", bus.active_io, bus.dout); end
        @(negedge clk);
        bus_idle();
        wait_spi_idle(cyc);
        n_checks++; if (bus.dout !== 8'h42) begin n_fail++; $display("FAIL spi_read2_rx: got %h want 42", bus.dout); end
    endtask

    task automatic test_nmi();
        @(negedge clk); nmi_button = 1'b1;
        @(negedge clk); nmi_button = 1'b0;
        n_checks++; if (nNMI !== 1'b0) begin n_fail++; $display("FAIL nmi_assert: got %b want 0", nNMI); end
        repeat (3) @(negedge clk);
        n_checks++; if (nNMI !== 1'b0) begin n_fail++; $display("FAIL nmi_latched: got %b want 0", nNMI); end
        fetch(16'h0066); m1_end();
        n_checks++; if (nNMI !== 1'b1 || bus.active !== 1'b1) begin n_fail++; $display("FAIL nmi_service: got nNMI=%b active=%b want 1/1", nNMI, bus.active); end
        nmi_button = 1'b1;
        @(negedge clk); nmi_button = 1'b0;
        @(negedge clk);
        n_checks++; if (nNMI !== 1'b1) begin n_fail++; $display("FAIL nmi_ignored_active: got %b want 1", nNMI); end
        fetch(16'h1FF8); m1_end();
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL nmi_exit: got %b want 0", bus.active); end
    endtask

    task automatic test_enable_abort();
        @(negedge clk);
        bus.addr = {8'h00, P_SPI}; bus.din = 8'h5A; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        @(negedge clk);
        bus_idle();
        repeat (9) @(negedge clk);
        n_checks++; if (spi_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", spi_busy); end
        enabled = 1'b0;
        @(negedge clk);
        n_checks++; if (spi_busy !== 1'b0 || sd_sck !== 1'b0 || sd_cs_n !== 2'b11) begin n_fail++; $display("FAIL abort_pins: got busy=%b sck=%b cs=%b want 0 0 11", spi_busy, sd_sck, sd_cs_n); end
        n_checks++; if (bus.dout !== 8'h42) begin n_fail++; $display("FAIL abort_dout_kept: got %h want 42", bus.dout); end
        enabled = 1'b1;
    endtask

    task automatic test_reset_mid_spi();
        io_write(P_CS, 8'hFE);
        @(negedge clk);
        bus.addr = {8'h00, P_SPI}; bus.din = 8'hC3; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        @(negedge clk);
        bus_idle();
        @(negedge clk); @(negedge clk);
        n_checks++; if (sd_sck !== 1'b1 || spi_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sck: got sck=%b busy=%b want 1/1", sd_sck, spi_busy); end
        #2 nRESET = 1'b0;
        #1;
        n_checks++; if (sd_sck !== 1'b0 || sd_cs_n !== 2'b11 || spi_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_pins: got sck=%b cs=%b busy=%b want 0 11 0", sd_sck, sd_cs_n, spi_busy); end
        n_checks++; if (bus.dout !== 8'hFF || sd_mosi !== 1'b1) begin n_fail++; $display("FAIL rst_async_dout: got dout=%h mosi=%b want ff/1", bus.dout, sd_mosi); end
        @(negedge clk); nRESET = 1'b1;
        fetch(16'h0000); m1_end();
        bus.addr = 16'h0100; #1;
        n_checks++; if (bus.active !== 1'b1 || bus.mapped_addr !== 20'h00100 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_clears_mapram: got %b/%h/%b want 1/00100/0", bus.active, bus.mapped_addr, bus.mem_wr_en); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET     = 1'b0;
        enabled    = 1'b1;
        nmi_button = 1'b0;
        bus.addr   = 16'h0000;
        bus.din    = 8'h00;
        bus_idle();
        test_reset();
        test_conmem();
        test_automap();
        test_mapram();
        test_spi();
        test_nmi();
        test_enable_abort();
        test_reset_mid_spi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
